axi4_lite_reg_slave: RTL
========================

Name: axi4_lite_reg_slave

Overview:
AXI4-lite responder endpoint that terminates one slave port of the AXI4-lite bus interconnect. It implements a bank of NUM_REGS word-wide registers. Each register is either read/write (software control) or read-only (hardware status). The s_axi_* signal set and the 1-bit response encoding (0=OKAY, 1=SLVERR) match the interconnect's slave-side ports one-to-one.

Parameters:
ADDR_WIDTH, 16, AXI address width; must match interconnect
DATA_WIDTH, 16, register/data width; multiple of 8
NUM_REGS, 4, number of registers (>=1)
OFFSET_BITS, 8, low address bits decoded as register offset; upper bits ignored (interconnect already decoded base)
RO_MASK, '0, NUM_REGS bits; bit i=1 makes reg i read-only (value from reg_in)
RESET_VALS, '0, NUM_REGS*DATA_WIDTH flat; reg i reset value in [DATA_WIDTH*i +: DATA_WIDTH]

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axi_awready  out  1  write address ready
s_axi_awvalid  in  1  write address valid
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_wready  out  1  write data ready
s_axi_wvalid  in  1  write data valid
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_bresp  out  1  0=OKAY, 1=SLVERR
s_axi_arready  out  1  read address ready
s_axi_arvalid  in  1  read address valid
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  1  0=OKAY, 1=SLVERR
reg_q  out  NUM_REGS*DATA_WIDTH  current register contents (RO slots drive reg_in value)
reg_in  in  NUM_REGS*DATA_WIDTH  hardware status values for RO registers; ignored for RW slots
reg_wr  out  NUM_REGS  one-cycle pulse on the cycle after a successful write commit to reg i

Behaviour:
- Decode: ADDR_LSB=$clog2(DATA_WIDTH/8). idx=addr[OFFSET_BITS-1:ADDR_LSB]. Misaligned low bits are ignored. idx>=NUM_REGS gives SLVERR.
- Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=0, rvalid=0, rdata=0, rresp=0, reg_wr=0. RW registers load RESET_VALS. Reset mid-transaction drops all buffered/pending state with no response issued.
- Write channel: AW and W are captured independently into 1-entry holding registers, in either order or the same cycle.
  - awready = !aw_full && !bvalid. wready = !w_full && !bvalid.
  - A handshake sets the full flag and drops the corresponding ready the next cycle.
- Write commit: happens on the edge where aw_full && w_full && !bvalid.
  - RW reg with idx in range: byte i updated iff wstrb[i]. bresp=0. reg_wr[idx] pulses high for exactly the following cycle.
  - RO reg or idx out of range: no update, bresp=1, no reg_wr pulse.
  - The same edge sets bvalid=1 and clears both full flags.
  - Latency: AW+W both accepted at edge N, commit at N+1, bvalid visible after N+1.
- B channel: bvalid and bresp are held stable until bready. bvalid clears on the bvalid&&bready edge. awready/wready reassert the cycle after.
- Read channel: arready = !rvalid.
  - On the arvalid&&arready edge, rdata is registered: reg_in slice for RO regs, register value for RW regs, 0 with rresp=1 for out-of-range idx. rvalid is set on the same edge.
  - Latency: 1 cycle.
  - rvalid, rdata and rresp are held until rready. rvalid clears on the handshake edge.
- Read/write collision: if a read accept and a write commit to the same reg fall on the same edge, rdata returns the pre-write value.
- Channel independence: read and write paths never block each other. At most one outstanding write and one outstanding read.
- reg_q is driven from the flops directly; it is not forwarded from the write path.

Decomposition:
- Package axi4_lite_pkg holds the response constants RESP_OKAY=1'b0 and RESP_SLVERR=1'b1, shared with the interconnect.
- No sub-module; write-path and read-path are separate always_ff blocks in one module.

Test Plan:
- AW then W 3 cycles later, addr 0x0002, wdata 0xBEEF, wstrb 2'b11 -> reg1=0xBEEF; bvalid 1 cycle after W accept; bresp=0; reg_wr=4'b0010 pulse for 1 cycle.
- Write reg0 (reset 0x1234) with wdata 0xABCD, wstrb 2'b10 -> reg0=0xAB34; bresp=0.
- Write addr 0x0008 (idx 4, out of range) and write RO reg2 -> bresp=1, registers unchanged, no reg_wr pulse. Read idx 4 -> rdata=0, rresp=1.
- Read RO reg2 with reg_in slice=0x5A5A -> rvalid 1 cycle after AR accept, rdata=0x5A5A, rresp=0. Hold rready=0 for 5 cycles -> rvalid/rdata stable and arready=0 throughout.
- Write reg3=0x1111 committing on the same edge as a reg3 read accept -> rdata=old value; a subsequent read returns 0x1111.
- bready held low 4 cycles -> awready=wready=0 and no second write accepted. Assert reset mid-hold -> all outputs return to reset values and reg1 reloads its RESET_VALS slice.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// axi4_lite_pkg : response encodings shared with the AXI4-lite interconnect
// Revision: 1.0
// ============================================================================
package axi4_lite_pkg;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// axi4_lite_reg_slave : AXI4-lite register bank endpoint with RW and RO slots
// Revision: 1.0
// ============================================================================
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REGS    = 4,
  parameter int OFFSET_BITS = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALS = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           s_axi_awready,
  input  logic                           s_axi_awvalid,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  output logic                           s_axi_wready,
  input  logic                           s_axi_wvalid,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  output logic                           s_axi_bresp,
  output logic                           s_axi_arready,
  input  logic                           s_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic                           s_axi_rresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = OFFSET_BITS - ADDR_LSB;
  localparam int SEL_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_WIDTH:0] NUM_REGS_W = NUM_REGS[IDX_WIDTH:0];

  function automatic logic idx_in_range(input logic [IDX_WIDTH-1:0] idx);
    return {1'b0, idx} < NUM_REGS_W;
  endfunction

  // Write-path state
  logic                  aw_full_q, aw_full_d;
  logic [IDX_WIDTH-1:0]  aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic                  bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Read-path state
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rresp_q, rresp_d;

  logic [IDX_WIDTH-1:0]  ar_idx;
  logic [SEL_WIDTH-1:0]  wr_sel;
  logic [SEL_WIDTH-1:0]  rd_sel;
  logic                  unused_addr_bits;

  assign ar_idx = s_axi_araddr[OFFSET_BITS-1:ADDR_LSB];
  assign wr_sel = aw_idx_q[SEL_WIDTH-1:0];
  assign rd_sel = ar_idx[SEL_WIDTH-1:0];
  // Upper address bits were already decoded by the interconnect.
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = !aw_full_q && !bvalid_q;
  assign s_axi_wready  = !w_full_q && !bvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign reg_wr        = reg_wr_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
    assign reg_q[DATA_WIDTH*gi +: DATA_WIDTH] =
      RO_MASK[gi] ? reg_in[DATA_WIDTH*gi +: DATA_WIDTH] : regs_q[gi];
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    reg_wr_d  = '0;
    regs_d    = regs_q;

    if (s_axi_awvalid && s_axi_awready) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axi_awaddr[OFFSET_BITS-1:ADDR_LSB];
    end
    if (s_axi_wvalid && s_axi_wready) begin
      w_full_d = 1'b1;
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end

    // Both halves captured and response slot free: commit.
    if (aw_full_q && w_full_q && !bvalid_q) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (idx_in_range(aw_idx_q) && !RO_MASK[wr_sel]) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (w_strb_q[b]) regs_d[wr_sel][8*b +: 8] = w_data_q[8*b +: 8];
        end
        bresp_d          = RESP_OKAY;
        reg_wr_d[wr_sel] = 1'b1;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end

    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      reg_wr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALS[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      reg_wr_q  <= reg_wr_d;
      regs_q    <= regs_d;
    end
  end

  // Reads sample regs_q, so a same-edge write commit returns the old value.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (s_axi_arvalid && s_axi_arready) begin
      rvalid_d = 1'b1;
      if (!idx_in_range(ar_idx)) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = RO_MASK[rd_sel] ? reg_in[DATA_WIDTH*rd_sel +: DATA_WIDTH]
                                  : regs_q[rd_sel];
      end
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule
`default_nettype wire
